// File: rtl/mod_cfg_sequencer.sv
// Run-time frequency/phase/duty sequencer for the CLK/CLKN/CLKL generator.
// Gates outputs, switches the PLL tap, waits for stable lock, re-enables.
// Ports: USER_CLOCK/RESET (async, active-high), LOCKED (async, synced here),
//   CFG_VALID/CFG_READY + REQ_*_SEL host request, FREQ/PHASE/DUTY_SEL live
//   selects, OUT_EN output gate, BUSY, sticky ERR_RANGE/ERR_TIMEOUT,
//   LOCK_LOSS_CNT (saturating lock losses while enabled).
// Option MOD_CFG_PHASE_SWEEP_EN adds SWEEP_GO/SWEEP_DWELL phase sweeping.
module mod_cfg_sequencer #(
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_STABLE   = 64,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int MAX_FREQ_CODE = 5
) (
  input  logic       USER_CLOCK,
  input  logic       RESET,
  input  logic       LOCKED,
`ifdef MOD_CFG_PHASE_SWEEP_EN
  input  logic       SWEEP_GO,
  input  logic [15:0] SWEEP_DWELL,
`endif
  input  logic       CFG_VALID,
  output logic       CFG_READY,
  input  logic [2:0] REQ_FREQ_SEL,
  input  logic [4:0] REQ_PHASE_SEL,
  input  logic [3:0] REQ_DUTY_SEL,
  output logic [2:0] FREQ_SEL,
  output logic [4:0] PHASE_SEL,
  output logic [3:0] DUTY_SEL,
  output logic       OUT_EN,
  output logic       BUSY,
  output logic       ERR_RANGE,
  output logic       ERR_TIMEOUT,
  output logic [7:0] LOCK_LOSS_CNT
);

  typedef enum logic [2:0] {
    S_IDLE, S_GATE, S_SETTLE, S_WAIT_LOCK, S_APPLY, S_ENABLE
  } state_t;

  localparam logic [15:0] L_GATE_LAST   = 16'(GATE_CYCLES - 1);
  localparam logic [15:0] L_SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] L_STABLE_LAST = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] L_TMO_LAST    = 16'(LOCK_TIMEOUT - 1);
  localparam logic [2:0]  L_MAX_FREQ    = 3'(MAX_FREQ_CODE);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [15:0] r_stable;
  logic        r_lock_s1;
  logic        r_lock_s2;
  logic        r_pending;
  logic [2:0]  r_req_freq;
  logic [4:0]  r_req_phase;
  logic [3:0]  r_req_duty;
  logic [2:0]  r_freq;
  logic [4:0]  r_phase;
  logic [3:0]  r_duty;
  logic        r_out_en;
  logic        r_err_range;
  logic        r_err_tmo;
  logic [7:0]  r_loss_cnt;

  logic w_locked;
  logic w_sweep_go;
  logic w_ready;
  logic w_accept;
  logic w_range_err;
  logic w_load_freq;
  logic w_apply;
  logic w_drop_req;
  logic w_enable;
  logic w_disable;
  logic w_tmo;
  logic w_loss;

  assign w_locked = r_lock_s2;

`ifdef MOD_CFG_PHASE_SWEEP_EN
  assign w_sweep_go = SWEEP_GO;
  logic [15:0] r_dwell;
`else
  assign w_sweep_go = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_range_err = 1'b0;
    w_load_freq = 1'b0;
    w_apply     = 1'b0;
    w_drop_req  = 1'b0;
    w_enable    = 1'b0;
    w_disable   = 1'b0;
    w_tmo       = 1'b0;
    w_loss      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Lock loss wins over a same-cycle request.
        w_loss  = r_out_en & ~w_locked;
        w_ready = ~w_loss & ~w_sweep_go;
        if (w_loss) begin
          w_next    = S_WAIT_LOCK;
          w_disable = 1'b1;
        end else if (CFG_VALID && w_ready) begin
          if (REQ_FREQ_SEL > L_MAX_FREQ) begin
            w_range_err = 1'b1;
          end else begin
            w_accept  = 1'b1;
            w_disable = 1'b1;
            w_next    = S_GATE;
          end
        end
      end
      S_GATE: begin
        if (r_cnt == L_GATE_LAST) begin
          if (r_req_freq == r_freq) begin
            w_next = S_APPLY;
          end else begin
            w_load_freq = 1'b1;
            w_next      = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (r_cnt == L_SETTLE_LAST) w_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_locked && r_stable == L_STABLE_LAST) begin
          w_next = S_APPLY;
        end else if (r_cnt == L_TMO_LAST) begin
          w_tmo      = 1'b1;
          w_drop_req = 1'b1;
          w_next     = S_IDLE;
        end
      end
      S_APPLY: begin
        // Reset/lock-loss recovery has no pending request: keep selects.
        w_apply    = r_pending;
        w_drop_req = 1'b1;
        w_next     = S_ENABLE;
      end
      S_ENABLE: begin
        w_enable = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge USER_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_WAIT_LOCK;
      r_cnt       <= '0;
      r_stable    <= '0;
      r_lock_s1   <= 1'b0;
      r_lock_s2   <= 1'b0;
      r_pending   <= 1'b0;
      r_req_freq  <= '0;
      r_req_phase <= '0;
      r_req_duty  <= '0;
      r_freq      <= 3'd0;
      r_phase     <= 5'd0;
      r_duty      <= 4'd8;
      r_out_en    <= 1'b0;
      r_err_range <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_loss_cnt  <= '0;
`ifdef MOD_CFG_PHASE_SWEEP_EN
      r_dwell     <= '0;
`endif
    end else begin
      r_lock_s1 <= LOCKED;
      r_lock_s2 <= r_lock_s1;
      r_state   <= w_next;
      if (w_next != r_state) begin
        r_cnt    <= '0;
        r_stable <= '0;
      end else begin
        r_cnt    <= r_cnt + 16'd1;
        r_stable <= w_locked ? r_stable + 16'd1 : 16'd0;
      end
      if (w_accept) begin
        r_req_freq  <= REQ_FREQ_SEL;
        r_req_phase <= REQ_PHASE_SEL;
        r_req_duty  <= REQ_DUTY_SEL;
        r_pending   <= 1'b1;
      end else if (w_drop_req) begin
        r_pending <= 1'b0;
      end
      if (w_load_freq) r_freq <= r_req_freq;
      if (w_apply) begin
        r_phase <= r_req_phase;
        r_duty  <= r_req_duty;
      end
      if (w_disable || w_tmo) r_out_en <= 1'b0;
      else if (w_enable)      r_out_en <= 1'b1;
      if (w_range_err) r_err_range <= 1'b1;
      if (w_tmo)       r_err_tmo   <= 1'b1;
      if (w_loss && r_loss_cnt != 8'hFF) r_loss_cnt <= r_loss_cnt + 8'd1;
`ifdef MOD_CFG_PHASE_SWEEP_EN
      if (r_state == S_IDLE && r_out_en && SWEEP_GO && !w_loss) begin
        if (r_dwell == SWEEP_DWELL) begin
          r_dwell <= '0;
          r_phase <= r_phase + 5'd1;
        end else begin
          r_dwell <= r_dwell + 16'd1;
        end
      end else begin
        r_dwell <= '0;
      end
`endif
    end
  end

  assign CFG_READY     = w_ready;
  assign BUSY          = (r_state != S_IDLE);
  assign FREQ_SEL      = r_freq;
  assign PHASE_SEL     = r_phase;
  assign DUTY_SEL      = r_duty;
  assign OUT_EN        = r_out_en;
  assign ERR_RANGE     = r_err_range;
  assign ERR_TIMEOUT   = r_err_tmo;
  assign LOCK_LOSS_CNT = r_loss_cnt;

endmodule

// File: tb/tb_mod_cfg_sequencer.sv
// Directed + randomized bench for mod_cfg_sequencer.
// Expected values come from a small request-level model of the sequencer.
module tb_mod_cfg_sequencer;

  localparam int G = 4;
  localparam int S = 16;
  localparam int L = 64;
  localparam int T = 50000;
  localparam int MAXF = 5;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] req_f = '0;
  logic [4:0] req_p = '0;
  logic [3:0] req_d = '0;
  logic [2:0] freq_sel;
  logic [4:0] phase_sel;
  logic [3:0] duty_sel;
  logic       out_en;
  logic       busy;
  logic       err_range;
  logic       err_tmo;
  logic [7:0] loss_cnt;

  int checks = 0;
  int failures = 0;

  int exp_f, exp_p, exp_d, exp_er, exp_et, exp_loss;

  always #5 clk = ~clk;

  mod_cfg_sequencer dut (
    .USER_CLOCK(clk), .RESET(rst), .LOCKED(locked),
    .CFG_VALID(cfg_valid), .CFG_READY(cfg_ready),
    .REQ_FREQ_SEL(req_f), .REQ_PHASE_SEL(req_p), .REQ_DUTY_SEL(req_d),
    .FREQ_SEL(freq_sel), .PHASE_SEL(phase_sel), .DUTY_SEL(duty_sel),
    .OUT_EN(out_en), .BUSY(busy), .ERR_RANGE(err_range),
    .ERR_TIMEOUT(err_tmo), .LOCK_LOSS_CNT(loss_cnt)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, "_freq"}, 32'(freq_sel), exp_f);
    check({tag, "_phase"}, 32'(phase_sel), exp_p);
    check({tag, "_duty"}, 32'(duty_sel), exp_d);
    check({tag, "_err_range"}, 32'(err_range), exp_er);
    check({tag, "_err_tmo"}, 32'(err_tmo), exp_et);
    check({tag, "_loss_cnt"}, 32'(loss_cnt), exp_loss);
  endtask

  // Drives one request; returns one sample (#1) after the accepting edge.
  task automatic send(input int f, input int p, input int d);
    @(negedge clk);
    check("ready_before_req", 32'(cfg_ready), 1);
    req_f = 3'(f);
    req_p = 5'(p);
    req_d = 4'(d);
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_en(input int limit, output int n);
    n = 0;
    while (out_en !== 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_freq(input int f, input int limit, output int n);
    n = 0;
    while (32'(freq_sel) != f && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  function automatic int low_cycles(input int f);
    return (f == exp_f) ? G + 2 : G + S + L + 2;
  endfunction

  task automatic model_reset();
    exp_f = 0; exp_p = 0; exp_d = 8;
    exp_er = 0; exp_et = 0; exp_loss = 0;
  endtask

  task automatic check_reset_vals(string tag);
    check_model(tag);
    check({tag, "_out_en"}, 32'(out_en), 0);
    check({tag, "_ready"}, 32'(cfg_ready), 0);
    check({tag, "_busy"}, 32'(busy), 1);
  endtask

  initial begin
    int n;
    int f, p, d;
    int low_bad;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");

    // Reset release with LOCKED high throughout.
    @(negedge clk);
    rst = 1'b0;
    wait_en(500, n);
    check("rst_lock_latency", n, SYNC + L + 2);
    check_model("rst_done");
    check("rst_done_ready", 32'(cfg_ready), 1);
    check("rst_done_busy", 32'(busy), 0);

    // Freq change with a 20-cycle lock drop after SETTLE.
    send(3, 10, 4);
    check("f3_out_en_gated", 32'(out_en), 0);
    wait_freq(3, 100, n);
    check("f3_freq_after_gate", n, G);
    check("f3_out_en_low_gate", 32'(out_en), 0);
    repeat (S) @(negedge clk);
    locked = 1'b0;
    low_bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_en !== 1'b0) low_bad++;
    end
    check("f3_out_en_low_unlock", low_bad, 0);
    @(negedge clk);
    locked = 1'b1;
    wait_en(500, n);
    check("f3_relock_latency", n, SYNC + L + 2);
    exp_f = 3; exp_p = 10; exp_d = 4;
    check_model("f3_done");

    // Same freq, phase/duty only.
    send(3, 31, 15);
    wait_en(500, n);
    check("pd_low_cycles", n, G + 2);
    exp_p = 31; exp_d = 15;
    check_model("pd_done");

    // Illegal frequency code.
    send(6, 1, 1);
    exp_er = 1;
    check_model("range");
    check("range_ready", 32'(cfg_ready), 1);
    check("range_out_en", 32'(out_en), 1);
    repeat (5) @(posedge clk);
    #1;
    check("range_out_en_later", 32'(out_en), 1);
    check("range_busy", 32'(busy), 0);

    // Randomized requests against the model.
    for (int i = 0; i < 8; i++) begin
      f = int'($urandom_range(0, 7));
      p = int'($urandom_range(0, 31));
      d = int'($urandom_range(0, 15));
      send(f, p, d);
      if (f > MAXF) begin
        exp_er = 1;
        check("rnd_bad_out_en", 32'(out_en), 1);
        check("rnd_bad_ready", 32'(cfg_ready), 1);
      end else begin
        wait_en(500, n);
        check("rnd_low_cycles", n, low_cycles(f));
        exp_f = f; exp_p = p; exp_d = d;
      end
      check_model("rnd");
    end

    // Lock timeout on a freq change.
    f = (exp_f + 1) % (MAXF + 1);
    send(f, 7, 3);
    locked = 1'b0;
    n = 0;
    while (err_tmo !== 1'b1 && n < T + 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("tmo_latency", n, G + S + T);
    exp_f = f; exp_et = 1;
    check_model("tmo");
    check("tmo_out_en", 32'(out_en), 0);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_ready", 32'(cfg_ready), 1);
    @(negedge clk);
    locked = 1'b1;
    repeat (4) @(posedge clk);
    send(f, 12, 6);
    wait_en(500, n);
    check("tmo_recover_low", n, G + 2);
    exp_p = 12; exp_d = 6;
    check_model("tmo_recover");

    // Repeated lock loss while enabled.
    for (int i = 1; i <= 258; i++) begin
      @(negedge clk);
      locked = 1'b0;
      repeat (SYNC) @(posedge clk);
      #1;
      if (i == 1) begin
        check("loss_ready_forced", 32'(cfg_ready), 0);
        check("loss_out_en_still", 32'(out_en), 1);
        req_f = 3'((exp_f + 1) % (MAXF + 1));
        req_p = 5'd1;
        req_d = 4'd1;
        cfg_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      if (i == 1) begin
        check("loss_out_en_off", 32'(out_en), 0);
        check("loss_busy", 32'(busy), 1);
      end
      @(negedge clk);
      locked = 1'b1;
      wait_en(500, n);
      check("loss_relock", n, SYNC + L + 2);
      check("loss_cnt", 32'(loss_cnt), exp_loss);
    end
    check_model("loss_done");

    // Async reset in the middle of SETTLE.
    f = (exp_f + 2) % (MAXF + 1);
    send(f, 20, 2);
    wait_freq(f, 100, n);
    check("mid_freq_after_gate", n, G);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    wait_en(500, n);
    check("mid_rst_lock_latency", n, SYNC + L + 2);
    check_model("mid_rst_done");
    check("mid_rst_ready", 32'(cfg_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
